// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic pipeline stage register with valid/ready handshake and flush
// Optional two-entry skid buffer enabled by defining PIPE_STAGE_SKID_EN.
module pipe_stage_reg #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic              accept;
  logic              emit;

  assign accept = in_valid && in_ready;
  assign emit   = m_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;

  // Registered ready: only the skid slot decides, so no path from out_ready.
  assign in_ready = !s_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ctrl  <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_ctrl  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      s_valid <= 1'b0;
      s_ctrl  <= '0;
    end else if (!m_valid || emit) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_ctrl  <= s_ctrl;
        s_valid <= accept;
        if (accept) begin
          s_data <= in_data;
          s_ctrl <= in_ctrl;
        end
      end else if (accept) begin
        m_valid <= 1'b1;
        m_data  <= in_data;
        m_ctrl  <= in_ctrl;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      s_valid <= 1'b1;
      s_data  <= in_data;
      s_ctrl  <= in_ctrl;
    end
  end

  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
`else
  assign in_ready = !m_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ctrl  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= in_data;
      m_ctrl  <= in_ctrl;
    end else if (emit) begin
      m_valid <= 1'b0;
    end
  end

  assign occupancy = {1'b0, m_valid};
`endif

  // Empty or flushed slots must never present live control downstream.
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_valid ? m_ctrl : '0;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and bubble-safe control fields. It replaces the fixed per-stage latches (IF/DE, DE/EX, EX/MEM, MEM/WB) of the RISC-V pipeline with one generic block: the payload is split into a data field and a control field, stalls propagate by back-pressure, and flushed or empty slots always present all-zero control so that no downstream write or branch fires. An optional two-entry skid buffer gives full throughput with a registered `in_ready`.

## Interface
- `DATA_W`, 160: width of the data payload (PC, PC+4, register data, immediate, register indices).
- `CTRL_W`, 20: width of the control payload (alu_op, srcs, dm_write, dm_ctrl, br_op, ru_data_src, ru_write).
- `clk` input 1: single clock; all state updates on the rising edge only.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous kill of every held entry (branch taken, exception).
- `in_valid` input 1: upstream stage presents a beat.
- `in_ready` output 1: stage can accept a beat this cycle.
- `in_data` input DATA_W: data payload.
- `in_ctrl` input CTRL_W: control payload.
- `out_valid` output 1: stage holds a beat for the downstream stage.
- `out_ready` input 1: downstream consumes the beat this cycle.
- `out_data` output DATA_W: held data payload.
- `out_ctrl` output CTRL_W: held control payload, forced to 0 whenever `out_valid`=0.
- `occupancy` output 2: number of held entries (0..2; 0..1 without skid).

## Operation
- Accept: `in_valid && in_ready` at a rising edge. Emit: `out_valid && out_ready` at a rising edge.
- Main register M drives the outputs. Skid register S (when compiled in) holds one overflow beat.
- Per edge, priority: `rst` > `flush` > normal update.
- `rst`: M and S invalid, `out_data`=0, internal control stored as 0, `occupancy`=0. `in_ready`=1 in the cycle after reset.
- `flush`: M and S invalid, any beat accepted on the same edge is discarded, `out_data` retains its last value, `out_ctrl`=0, `occupancy`=0. The upstream still observes the handshake as completed; the data is dropped.
- Normal update, skid build:
  - M empty or emitting: M loads S if S is valid (S becomes invalid, and the input beat, if accepted, moves into S), else M loads the accepted input beat, else M becomes invalid.
  - M full and not emitting: an accepted input beat loads S.
  - `in_ready` = !S_valid (registered; no combinational path from `out_ready`).
- Normal update, non-skid build: `in_ready` = !M_valid || `out_ready` (combinational); an accepted beat loads M; emit without accept leaves M invalid.
- Ordering: beats emerge strictly in acceptance order; none duplicated or lost except by `flush`/`rst`.
- `out_ctrl` masking is combinational on `out_valid`; `out_data` is not masked.

## Timing
- Latency: a beat accepted at edge N appears on `out_*` after edge N, so it is emittable at edge N+1.
- Throughput: one beat per cycle with `out_ready` held at 1 in both builds.
- Skid build: after `out_ready` drops, at most 2 beats are held. `in_ready` falls one cycle after S fills and rises one cycle after S drains.
- Simultaneous emit and accept with M full: M takes the new beat (or S's beat) on the same edge, with no bubble.
- `flush` asserted for k cycles: `out_valid`=0 for those k cycles plus nothing extra; the next beat is accepted on the first edge with `flush`=0.
- `rst` mid-stall clears everything on that edge, whatever the `in_*`/`out_*` state.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: skid register S present, registered `in_ready`, `occupancy` ranges 0..2.
- Not defined: S removed, `in_ready` is combinational from `out_ready`, `occupancy`[1] tied to 0. All other behaviour is identical.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid`=1 and `in_data`=0xFF..F -> `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, then `in_ready`=1.
- Streaming: 8 beats with `in_data`=1..8 and `in_ctrl`=0x1F, `out_ready`=1 -> outputs 1..8 on consecutive cycles, each one cycle after its accept, with no bubbles.
- Back-pressure (skid): `out_ready`=0 while sending 1,2,3 -> beats 1 and 2 held, `in_ready`=0 before beat 3, `occupancy`=2. Then release `out_ready` -> output order 1,2,3 and no loss.
- Flush with accept: M=5, S=6, `flush`=1 and `in_valid`=1 with `in_data`=7 on the same edge -> `out_valid`=0 and `out_ctrl`=0 next cycle. Beat 8 sent afterwards emerges as the next output, and 5, 6 and 7 never appear.
- Bubble masking: `in_ctrl`=0xFFFFF accepted and then emitted with no new input -> after the emit `out_valid`=0 and `out_ctrl`=0, while `out_data` still shows the old payload.
- Non-skid build: `out_ready` toggling 1,0,1,0 with continuous input -> `in_ready` mirrors `out_ready` whenever M is full, and outputs stay in order with `occupancy` never exceeding 1.
